div_scheduler: RTL

- Sequencer and arbiter that shares one divider datapath between two requesters: requester 0 is the core M-extension unit, requester 1 is the encryption accelerator.
- Accepts requests over valid/ready, chooses between them round-robin, and registers the operands.
- Drives the divider's oper_a/oper_b/fuct3/enable_div inputs and waits for div_finish, or times out.
- Returns the result and the divide-by-zero flag to the requester that was granted, over valid/ready.

---
 rtl/div_sched_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/div_scheduler.sv | 130 +++++++++++++
 3 files changed

// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler.
package div_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  // Operation select carried on req_funct / div_fuct3.
  localparam logic FUNCT_DIV = 1'b1;
  localparam logic FUNCT_REM = 1'b0;

  // Requester indices.
  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_ACC  = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant. Purely combinational; the caller keeps last_grant.
module rr_arbiter2
  import div_sched_pkg::*;
(
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       grant_valid
);

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant_valid = |req_valid;
    grant       = REQ_CORE;
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end else if (req_valid[1]) begin
      grant = REQ_ACC;
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one divider between the core M unit (requester 0) and the
// encryption accelerator (requester 1). Requests are accepted only in IDLE,
// the divider is driven during ISSUE, and the result is held in RESP until
// the granted requester takes it.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter int unsigned LENGTH   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [LENGTH-1:0] req0_a,
  input  logic [LENGTH-1:0] req0_b,
  input  logic [LENGTH-1:0] req1_a,
  input  logic [LENGTH-1:0] req1_b,
  input  logic [1:0]        req_funct,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [LENGTH-1:0] rsp_result,
  output logic              rsp_dbz,
  output logic              rsp_err,
  output logic [LENGTH-1:0] div_oper_a,
  output logic [LENGTH-1:0] div_oper_b,
  output logic              div_fuct3,
  output logic              div_enable,
  input  logic [LENGTH-1:0] div_o,
  input  logic              div_finish,
  input  logic              div_dbz
);

  localparam int unsigned WCW = $clog2(MAX_WAIT) + 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

  state_t            state;
  logic              last_grant;
  logic              owner;
  logic [LENGTH-1:0] op_a;
  logic [LENGTH-1:0] op_b;
  logic              op_funct;
  logic [WCW-1:0]    wait_cnt;

  logic              grant;
  logic              grant_valid;
  logic              req_hs;

  rr_arbiter2 u_arb (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

  // Ready only toward the granted requester, only in IDLE and never during reset.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && !rst && grant_valid) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign req_hs     = |(req_valid & req_ready);
  assign div_oper_a = op_a;
  assign div_oper_b = op_b;
  assign div_fuct3  = op_funct;

  // Sequencer: capture request, drive divider until finish or timeout, hold response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_ACC;
      owner      <= REQ_CORE;
      op_a       <= '0;
      op_b       <= '0;
      op_funct   <= 1'b0;
      wait_cnt   <= '0;
      div_enable <= 1'b0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_dbz    <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_hs) begin
            owner      <= grant;
            last_grant <= grant;
            op_a       <= (grant == REQ_ACC) ? req1_a : req0_a;
            op_b       <= (grant == REQ_ACC) ? req1_b : req0_b;
            op_funct   <= req_funct[grant];
            wait_cnt   <= '0;
            div_enable <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (div_finish) begin
            rsp_result <= div_o;
            rsp_dbz    <= div_dbz;
            rsp_err    <= 1'b0;
            rsp_valid  <= (owner == REQ_ACC) ? 2'b10 : 2'b01;
            div_enable <= 1'b0;
            state      <= RESP;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_result <= '0;
            rsp_dbz    <= 1'b0;
            rsp_err    <= 1'b1;
            rsp_valid  <= (owner == REQ_ACC) ? 2'b10 : 2'b01;
            div_enable <= 1'b0;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
